// File: rtl/fb_mem_arbiter.sv
// Framebuffer RAM arbiter: VGA scanout has priority, CPU is
// guaranteed a slot after VGA_BURST consecutive VGA wins.
//   clock_50/reset : clock, sync active-high reset
//   vga_*          : VGA read port (req/addr -> gnt, rdata/rvalid)
//   cpu_*          : CPU read/write port (req/we/addr/wdata -> gnt, rdata/rvalid)
//   mem_*          : single-port RAM, read data one cycle after access
module fb_mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int VGA_BURST = 8
) (
  input  logic              clock_50,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(VGA_BURST) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(VGA_BURST - 1);

  typedef enum logic {
    S_VGA,
    S_CPU
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] cnt_nxt;
  logic          vga_pend;
  logic          cpu_pend;

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state      <= S_VGA;
      starve_cnt <= '0;
      vga_pend   <= 1'b0;
      cpu_pend   <= 1'b0;
      vga_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      vga_rdata  <= '0;
      cpu_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= cnt_nxt;
      vga_pend   <= vga_gnt;
      cpu_pend   <= cpu_gnt & ~cpu_we;
      vga_rvalid <= vga_pend;
      cpu_rvalid <= cpu_pend;
      if (vga_pend) vga_rdata <= mem_rdata;
      if (cpu_pend) cpu_rdata <= mem_rdata;
    end
  end

  always_comb begin
    vga_gnt   = 1'b0;
    cpu_gnt   = 1'b0;
    state_nxt = state;
    cnt_nxt   = '0;
    if (!reset) begin
      unique case (state)
        S_VGA: begin
          if (vga_req) begin
            vga_gnt = 1'b1;
            // CPU lost this cycle; force its slot once the burst is used up
            if (cpu_req) begin
              if (starve_cnt == CNT_MAX) state_nxt = S_CPU;
              else cnt_nxt = starve_cnt + CW'(1);
            end
          end else if (cpu_req) begin
            cpu_gnt = 1'b1;
          end
        end
        S_CPU: begin
          state_nxt = S_VGA;
          if (cpu_req) cpu_gnt = 1'b1;
          else if (vga_req) vga_gnt = 1'b1;
        end
        default: state_nxt = S_VGA;
      endcase
    end
  end

  always_comb begin
    mem_en    = vga_gnt | cpu_gnt;
    mem_we    = cpu_gnt & cpu_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (vga_gnt) begin
      mem_addr = vga_addr;
    end
  end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter with a behavioural 1-cycle RAM.
// Inputs change 1ns after posedge; outputs are checked 3ns after posedge.
module tb_fb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        vga_req;
  logic [15:0] vga_addr;
  logic        vga_gnt;
  logic [7:0]  vga_rdata;
  logic        vga_rvalid;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  int total = 0;
  int bad   = 0;

  logic [7:0] wr_map [int];

  always #5 clk = ~clk;

  fb_mem_arbiter #(
    .ADDR_W(16),
    .DATA_W(8),
    .VGA_BURST(8)
  ) dut (
    .clock_50  (clk),
    .reset     (reset),
    .vga_req   (vga_req),
    .vga_addr  (vga_addr),
    .vga_gnt   (vga_gnt),
    .vga_rdata (vga_rdata),
    .vga_rvalid(vga_rvalid),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rdata (cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [7:0] dflt(input logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) wr_map[int'(mem_addr)] = mem_wdata;
      else if (wr_map.exists(int'(mem_addr)))
        mem_rdata <= wr_map[int'(mem_addr)];
      else
        mem_rdata <= dflt(mem_addr);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    vga_req   = 1'b0;
    vga_addr  = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;

    // reset: requests present but nothing granted
    next_cyc;
    vga_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
    #2;
    check("rst_vgnt", 32'(vga_gnt), 0);
    check("rst_cgnt", 32'(cpu_gnt), 0);
    check("rst_men", 32'(mem_en), 0);
    check("rst_mwe", 32'(mem_we), 0);

    // idle after release
    next_cyc;
    reset = 1'b0; vga_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    #2;
    check("idle_men", 32'(mem_en), 0);
    check("idle_vrv", 32'(vga_rvalid), 0);
    check("idle_crv", 32'(cpu_rvalid), 0);
    check("idle_vrd", 32'(vga_rdata), 0);
    check("idle_crd", 32'(cpu_rdata), 0);

    // VGA-only stream of 4 reads
    for (int c = 0; c < 8; c++) begin
      next_cyc;
      vga_req  = (c < 4);
      vga_addr = 16'(c);
      #2;
      check("vs_gnt", 32'(vga_gnt), 32'(c < 4));
      check("vs_cgnt", 32'(cpu_gnt), 0);
      if (c < 4) check("vs_addr", 32'(mem_addr), 32'(c));
      check("vs_rv", 32'(vga_rvalid), 32'(c >= 2 && c < 6));
      if (c >= 2 && c < 6)
        check("vs_rd", 32'(vga_rdata), 32'(dflt(16'(c - 2))));
      check("vs_crv", 32'(cpu_rvalid), 0);
    end

    // CPU write then read back
    next_cyc;
    vga_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 16'h0010; cpu_wdata = 8'hA5;
    #2;
    check("cw_gnt", 32'(cpu_gnt), 1);
    check("cw_mwe", 32'(mem_we), 1);
    check("cw_addr", 32'(mem_addr), 32'h10);
    check("cw_wd", 32'(mem_wdata), 32'hA5);
    next_cyc;
    cpu_we = 1'b0;
    #2;
    check("cr_gnt", 32'(cpu_gnt), 1);
    check("cr_mwe", 32'(mem_we), 0);
    check("cr_rv_w", 32'(cpu_rvalid), 0);
    next_cyc;
    cpu_req = 1'b0;
    #2;
    check("cr_rv0", 32'(cpu_rvalid), 0);
    next_cyc;
    #2;
    check("cr_rv1", 32'(cpu_rvalid), 1);
    check("cr_rd", 32'(cpu_rdata), 32'hA5);
    next_cyc;
    #2;
    check("cr_rv2", 32'(cpu_rvalid), 0);
    check("cr_hold", 32'(cpu_rdata), 32'hA5);

    // full contention: 8 VGA then 1 CPU, twice
    for (int c = 0; c < 18; c++) begin
      next_cyc;
      vga_req = 1'b1; vga_addr = 16'(c);
      cpu_req = 1'b1; cpu_we = 1'b1;
      cpu_addr = 16'h0020; cpu_wdata = 8'(c);
      #2;
      check("ct_vgnt", 32'(vga_gnt), 32'(c % 9 != 8));
      check("ct_cgnt", 32'(cpu_gnt), 32'(c % 9 == 8));
      check("ct_mwe", 32'(mem_we), 32'(c % 9 == 8));
    end
    next_cyc;
    vga_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;

    // CPU drops request while its slot is pending
    for (int c = 0; c < 18; c++) begin
      next_cyc;
      vga_req = 1'b1; vga_addr = 16'(c);
      cpu_req = (c != 8); cpu_we = 1'b0;
      cpu_addr = 16'h0010;
      #2;
      check("dr_vgnt", 32'(vga_gnt), 32'(c != 17));
      check("dr_cgnt", 32'(cpu_gnt), 32'(c == 17));
    end
    next_cyc;
    vga_req = 1'b0; cpu_req = 1'b0;
    next_cyc;
    next_cyc;

    // reset right after a VGA read grant flushes the pipeline
    next_cyc;
    vga_req = 1'b1; vga_addr = 16'h0003;
    #2;
    check("rr_gnt", 32'(vga_gnt), 1);
    next_cyc;
    reset = 1'b1; cpu_req = 1'b1;
    #2;
    check("rr_vgnt", 32'(vga_gnt), 0);
    check("rr_cgnt", 32'(cpu_gnt), 0);
    check("rr_men", 32'(mem_en), 0);
    next_cyc;
    reset = 1'b0; vga_req = 1'b0; cpu_req = 1'b0;
    #2;
    check("rr_rv0", 32'(vga_rvalid), 0);
    check("rr_rd0", 32'(vga_rdata), 0);
    next_cyc;
    #2;
    check("rr_rv1", 32'(vga_rvalid), 0);
    next_cyc;
    vga_req = 1'b1; vga_addr = 16'h0002;
    #2;
    check("rr_gnt2", 32'(vga_gnt), 1);
    next_cyc;
    vga_req = 1'b0;
    next_cyc;
    #2;
    check("rr_rv2", 32'(vga_rvalid), 1);
    check("rr_rd2", 32'(vga_rdata), 32'(dflt(16'h0002)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
